// File: rtl/cannon_bullet_pkg.sv
// Shared playfield constants and FSM state type for the cannon/bullet block.
package cannon_bullet_pkg;

  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 16;

  localparam logic [3:0] PARK_ROW    = 4'd15;
  localparam logic [3:0] LAUNCH_ROW  = 4'd14;
  localparam logic [4:0] CANNON_HOME = 5'd9;
  localparam logic [4:0] COL_MAX     = 5'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    FLIGHT = 2'd2
  } state_e;

endpackage

// File: rtl/cannon_bullet_tick_timer.sv
// Free-running prescaler: emits a one-cycle tick every CYCLES enabled cycles,
// then wraps to zero. A synchronous clear restarts the period.
module tick_timer #(
  parameter int unsigned CYCLES = 1800000
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] TERM = W'(CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  assign tick = en && (count_q == TERM);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cannon_bullet.sv
// Player cannon and single bullet: launches on a fire edge, climbs one row per
// step tick, parks on hit or on leaving the top row; counts hits into score.
module cannon_bullet
  import cannon_bullet_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1800000,
  parameter int unsigned MOVE_CYCLES = 3600000
) (
  input  logic       clk_36MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       fire,
  input  logic       left,
  input  logic       right,
  input  logic       hit,
  output logic [4:0] bullet_x,
  output logic [3:0] bullet_y,
  output logic       bullet_active,
  output logic [4:0] cannon_x,
  output logic [7:0] score
);

  state_e     state_q, state_d;
  logic [4:0] cannon_q, cannon_d;
  logic [4:0] bx_q, bx_d;
  logic [3:0] by_q, by_d;
  logic       active_q, active_d;
  logic [7:0] score_q, score_d;
  logic       fire_prev_q, fire_prev_d;

  logic step_tick, move_tick;
  logic step_clr, move_clr;
  logic run_en;
  logic fire_edge;

  assign run_en    = (state_q != IDLE);
  assign fire_edge = fire && !fire_prev_q;

  tick_timer #(.CYCLES(STEP_CYCLES)) u_step_timer (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .clr       (step_clr),
    .en        (run_en),
    .tick      (step_tick)
  );

  tick_timer #(.CYCLES(MOVE_CYCLES)) u_move_timer (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .clr       (move_clr),
    .en        (run_en),
    .tick      (move_tick)
  );

  always_comb begin
    state_d     = state_q;
    cannon_d    = cannon_q;
    bx_d        = bx_q;
    by_d        = by_q;
    active_d    = active_q;
    score_d     = score_q;
    fire_prev_d = fire;
    step_clr    = 1'b0;
    move_clr    = 1'b0;

    if (start) begin
      state_d  = READY;
      cannon_d = CANNON_HOME;
      bx_d     = 5'd0;
      by_d     = PARK_ROW;
      active_d = 1'b0;
      score_d  = 8'd0;
      step_clr = 1'b1;
      move_clr = 1'b1;
    end else begin
      // Cannon movement is independent of the bullet; launch uses the pre-move column.
      if (run_en && move_tick) begin
        if (left && !right && cannon_q != 5'd0) begin
          cannon_d = cannon_q - 5'd1;
        end else if (right && !left && cannon_q != COL_MAX) begin
          cannon_d = cannon_q + 5'd1;
        end
      end

      case (state_q)
        READY: begin
          if (fire_edge) begin
            state_d  = FLIGHT;
            bx_d     = cannon_q;
            by_d     = LAUNCH_ROW;
            active_d = 1'b1;
            step_clr = 1'b1;
          end
        end
        FLIGHT: begin
          if (hit) begin
            state_d  = READY;
            bx_d     = 5'd0;
            by_d     = PARK_ROW;
            active_d = 1'b0;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else if (step_tick) begin
            if (by_q == 4'd0) begin
              state_d  = READY;
              bx_d     = 5'd0;
              by_d     = PARK_ROW;
              active_d = 1'b0;
            end else begin
              by_d = by_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cannon_q    <= CANNON_HOME;
      bx_q        <= 5'd0;
      by_q        <= PARK_ROW;
      active_q    <= 1'b0;
      score_q     <= 8'd0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cannon_q    <= cannon_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      active_q    <= active_d;
      score_q     <= score_d;
      fire_prev_q <= fire_prev_d;
    end
  end

  assign bullet_x      = bx_q;
  assign bullet_y      = by_q;
  assign bullet_active = active_q;
  assign cannon_x      = cannon_q;
  assign score         = score_q;

endmodule

// File: tb/tb_cannon_bullet.sv
// Directed bench for cannon_bullet with short prescalers; expected outputs are
// queued when stimulus is applied and compared once the cycles have elapsed.
module tb_cannon_bullet;

  logic       clk_36MHz = 1'b0;
  logic       reset;
  logic       start, fire, left, right, hit;
  logic [4:0] bullet_x;
  logic [3:0] bullet_y;
  logic       bullet_active;
  logic [4:0] cannon_x;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] bx;
    logic [3:0] by;
    logic       act;
    logic [4:0] cx;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];

  cannon_bullet #(.STEP_CYCLES(4), .MOVE_CYCLES(2)) dut (
    .clk_36MHz     (clk_36MHz),
    .reset         (reset),
    .start         (start),
    .fire          (fire),
    .left          (left),
    .right         (right),
    .hit           (hit),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .cannon_x      (cannon_x),
    .score         (score)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_36MHz);
    #1;
  endtask

  task automatic push(input string tag, input logic [4:0] bx, input logic [3:0] by,
                      input logic act, input logic [4:0] cx, input logic [7:0] sc);
    exp_t e;
    e.tag = tag; e.bx = bx; e.by = by; e.act = act; e.cx = cx; e.sc = sc;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "bullet_x", 8'(bullet_x), 8'(e.bx));
      chk(e.tag, "bullet_y", 8'(bullet_y), 8'(e.by));
      chk(e.tag, "active",   8'(bullet_active), 8'(e.act));
      chk(e.tag, "cannon_x", 8'(cannon_x), 8'(e.cx));
      chk(e.tag, "score",    score, e.sc);
      $display("[%0t] %s bx=%0d by=%0d act=%0d cx=%0d score=%0d", $time, e.tag,
               bullet_x, bullet_y, bullet_active, cannon_x, score);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; fire = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;

    // Reset values
    #12;
    push("reset", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    check_out();
    @(posedge clk_36MHz); #1;
    reset = 1'b1;

    // IDLE ignores fire/left/hit
    fire = 1'b1; push("idle_ignore", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; left = 1'b1; hit = 1'b1;
    cyc(3); left = 1'b0; hit = 1'b0;
    check_out();

    // Start, launch, climb to row 0, park on 15th tick
    start = 1'b1; push("start", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); start = 1'b0; check_out();
    fire = 1'b1; push("launch", 5'd9, 4'd14, 1'b1, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; check_out();
    push("y1_at_55", 5'd9, 4'd1, 1'b1, 5'd9, 8'd0);
    cyc(55); check_out();
    push("y0_at_56", 5'd9, 4'd0, 1'b1, 5'd9, 8'd0);
    cyc(1); check_out();
    push("y0_at_59", 5'd9, 4'd0, 1'b1, 5'd9, 8'd0);
    cyc(3); check_out();
    push("park_top", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); check_out();

    // Cannon movement and clamping
    start = 1'b1; right = 1'b1; push("mv_start", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); start = 1'b0; check_out();
    push("mv_r1", 5'd0, 4'd15, 1'b0, 5'd10, 8'd0);
    cyc(2); check_out();
    push("mv_r1_hold", 5'd0, 4'd15, 1'b0, 5'd10, 8'd0);
    cyc(1); check_out();
    push("mv_r19", 5'd0, 4'd15, 1'b0, 5'd19, 8'd0);
    cyc(17); check_out();
    push("mv_clamp19", 5'd0, 4'd15, 1'b0, 5'd19, 8'd0);
    cyc(20); check_out();
    left = 1'b1; push("mv_both", 5'd0, 4'd15, 1'b0, 5'd19, 8'd0);
    cyc(4); check_out();
    right = 1'b0; push("mv_l2", 5'd0, 4'd15, 1'b0, 5'd17, 8'd0);
    cyc(4); check_out();
    push("mv_clamp0", 5'd0, 4'd15, 1'b0, 5'd0, 8'd0);
    cyc(40); check_out();
    left = 1'b0;

    // Hit at row 10, hit outside flight, relaunch from moved cannon, hit vs step tick
    start = 1'b1; push("h_start", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); start = 1'b0; check_out();
    fire = 1'b1; push("h_launch", 5'd9, 4'd14, 1'b1, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; check_out();
    push("h_y10", 5'd9, 4'd10, 1'b1, 5'd9, 8'd0);
    cyc(16); check_out();
    hit = 1'b1; push("h_hit", 5'd0, 4'd15, 1'b0, 5'd9, 8'd1);
    cyc(1); hit = 1'b0; check_out();
    hit = 1'b1; push("h_idlehit", 5'd0, 4'd15, 1'b0, 5'd9, 8'd1);
    cyc(1); hit = 1'b0; check_out();
    right = 1'b1; push("h_move", 5'd0, 4'd15, 1'b0, 5'd11, 8'd1);
    cyc(3); right = 1'b0; check_out();
    fire = 1'b1; push("h_relaunch", 5'd11, 4'd14, 1'b1, 5'd11, 8'd1);
    cyc(1); fire = 1'b0; check_out();
    cyc(3);
    hit = 1'b1; push("h_hit_tick", 5'd0, 4'd15, 1'b0, 5'd11, 8'd2);
    cyc(1); hit = 1'b0; check_out();

    // Held fire launches once; fire pulse in flight is neither taken nor queued
    start = 1'b1; push("f_start", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); start = 1'b0; check_out();
    fire = 1'b1; push("f_launch", 5'd9, 4'd14, 1'b1, 5'd9, 8'd0);
    cyc(1); check_out();
    push("f_park", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(60); check_out();
    push("f_no_repeat", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(10); check_out();
    fire = 1'b0; cyc(1);
    fire = 1'b1; push("f_launch2", 5'd9, 4'd14, 1'b1, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; check_out();
    cyc(2);
    fire = 1'b1; cyc(1); fire = 1'b0;
    push("f_no_relaunch", 5'd9, 4'd13, 1'b1, 5'd9, 8'd0);
    cyc(2); check_out();
    push("f_park2", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(55); check_out();
    push("f_no_queue", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(5); check_out();

    // Reset mid-flight at row 7
    start = 1'b1; right = 1'b1; push("r_start", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); start = 1'b0; check_out();
    push("r_move", 5'd0, 4'd15, 1'b0, 5'd11, 8'd0);
    cyc(4); right = 1'b0; check_out();
    fire = 1'b1; push("r_launch", 5'd11, 4'd14, 1'b1, 5'd11, 8'd0);
    cyc(1); fire = 1'b0; check_out();
    push("r_y7", 5'd11, 4'd7, 1'b1, 5'd11, 8'd0);
    cyc(28); check_out();
    #2; reset = 1'b0;
    push("r_async", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    #1; check_out();
    @(posedge clk_36MHz); #1;
    reset = 1'b1;
    fire = 1'b1; push("r_fire_ignored", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; cyc(4); check_out();
    start = 1'b1; cyc(1); start = 1'b0;
    fire = 1'b1; push("r_relaunch", 5'd9, 4'd14, 1'b1, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; check_out();

    // start wins over hit; score saturation
    hit = 1'b1; push("s_hit1", 5'd0, 4'd15, 1'b0, 5'd9, 8'd1);
    cyc(1); hit = 1'b0; check_out();
    fire = 1'b1; cyc(1); fire = 1'b0;
    hit = 1'b1; start = 1'b1; push("s_start_hit", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); hit = 1'b0; start = 1'b0; check_out();
    for (int i = 0; i < 255; i++) begin
      fire = 1'b1; cyc(1);
      fire = 1'b0; hit = 1'b1; cyc(1);
      hit = 1'b0;
    end
    push("s_255", 5'd0, 4'd15, 1'b0, 5'd9, 8'd255);
    check_out();
    fire = 1'b1; cyc(1);
    fire = 1'b0; hit = 1'b1; push("s_sat", 5'd0, 4'd15, 1'b0, 5'd9, 8'd255);
    cyc(1); hit = 1'b0; check_out();

    // start wins over fire; the held fire does not launch afterwards
    start = 1'b1; fire = 1'b1; push("s_start_fire", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); start = 1'b0; check_out();
    push("s_fire_held", 5'd0, 4'd15, 1'b0, 5'd9, 8'd0);
    cyc(1); fire = 1'b0; check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
